stream_border_skid: RTL and testbench

Registered Avalon-ST output stage placed directly downstream of the 3x3 convolution filter, ahead of the VGA output path. It breaks the filter's combinational ready/valid path with a 2-entry skid buffer, tracks pixel position per frame, replaces border pixels (where the 3x3 window is invalid) with a constant colour, and polices SOP/EOP framing. It reports malformed frames and counts good ones.

---
 rtl/stream_border_skid.sv | 220 ++++++++++++++++++++++
 tb/tb_stream_border_skid.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_border_skid.sv
// stream_border_skid: registered Avalon-ST output stage after the 3x3 filter.
// A 2-entry skid buffer (output register + skid register) isolates the
// upstream ready path. Pixel position is tracked per frame so that border
// pixels (incomplete 3x3 window) get a constant colour, and SOP/EOP framing
// is policed: malformed frames raise a one-cycle frame_error pulse and
// correctly framed frames are counted.
module stream_border_skid #(
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned HEIGHT       = 480,
  parameter logic [29:0] BORDER_COLOR = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] data_in,
  input  logic        startofpacket_in,
  input  logic        endofpacket_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [29:0] data_out,
  output logic        startofpacket_out,
  output logic        endofpacket_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        frame_error,
  output logic [15:0] frame_count
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic          out_valid_q, out_valid_d;
  logic [29:0]   out_data_q, out_data_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;

  logic          skid_valid_q, skid_valid_d;
  logic [29:0]   skid_data_q, skid_data_d;
  logic          skid_sop_q, skid_sop_d;
  logic          skid_eop_q, skid_eop_d;

  logic          ready_q;
  logic          frame_error_q, frame_error_d;
  logic [15:0]   frame_count_q, frame_count_d;

  // Per-beat classification results
  logic          accept;
  logic          fwd;
  logic          beat_err;
  logic          count_inc;
  logic          at_last;
  logic          border;
  logic          beat_eop;
  logic [29:0]   beat_data;
  logic [XW-1:0] px;
  logic [YW-1:0] py;

  assign accept = valid_in & ready_q;

  // Framing FSM: decide position, forwarding, error and count for each accepted beat
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    fwd       = 1'b0;
    beat_err  = 1'b0;
    count_inc = 1'b0;
    at_last   = 1'b0;
    beat_eop  = endofpacket_in;
    px        = x_q;
    py        = y_q;
    if (accept) begin
      fwd = 1'b1;
      if (startofpacket_in) begin
        // SOP always restarts at (0,0); inside a frame it truncates the previous one
        beat_err = (state_q == ACTIVE);
        px       = '0;
        py       = '0;
      end else if (state_q == IDLE) begin
        // Stray beat outside a frame is dropped
        fwd      = 1'b0;
        beat_err = 1'b1;
      end
      if (fwd) begin
        at_last = (px == X_LAST) && (py == Y_LAST);
        if (endofpacket_in) begin
          if (at_last) begin
            count_inc = 1'b1;
          end else begin
            beat_err = 1'b1;
          end
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (at_last) begin
          // Frame reached its last pixel without EOP: close it ourselves
          beat_eop = 1'b1;
          beat_err = 1'b1;
          state_d  = IDLE;
          x_d      = '0;
          y_d      = '0;
        end else begin
          state_d = ACTIVE;
          if (px == X_LAST) begin
            x_d = '0;
            y_d = py + 1'b1;
          end else begin
            x_d = px + 1'b1;
            y_d = py;
          end
        end
      end
    end
  end

  // Border substitution where the 3x3 window would be incomplete
  always_comb begin
    border    = (px == '0) || (px == X_LAST) || (py == '0) || (py == Y_LAST);
    beat_data = border ? BORDER_COLOR : data_in;
  end

  // Skid buffer next state: output register refills from skid first, else from input
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sop_d   = skid_sop_q;
    skid_eop_d   = skid_eop_q;
    if (!out_valid_q || ready_in) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sop_d    = skid_sop_q;
        out_eop_d    = skid_eop_q;
        skid_valid_d = fwd;
        if (fwd) begin
          skid_data_d = beat_data;
          skid_sop_d  = startofpacket_in;
          skid_eop_d  = beat_eop;
        end
      end else begin
        out_valid_d = fwd;
        if (fwd) begin
          out_data_d = beat_data;
          out_sop_d  = startofpacket_in;
          out_eop_d  = beat_eop;
        end
      end
    end else if (fwd) begin
      // Output is stalled: the accepted beat parks in the skid register
      skid_valid_d = 1'b1;
      skid_data_d  = beat_data;
      skid_sop_d   = startofpacket_in;
      skid_eop_d   = beat_eop;
    end
  end

  // Status next state: error pulse and good-frame counter
  always_comb begin
    frame_error_d = beat_err;
    frame_count_d = frame_count_q + {15'd0, count_inc};
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_sop_q    <= 1'b0;
      skid_eop_q    <= 1'b0;
      ready_q       <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_sop_q    <= skid_sop_d;
      skid_eop_q    <= skid_eop_d;
      ready_q       <= ~skid_valid_d;
      frame_error_q <= frame_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ready_out         = ready_q;
  assign valid_out         = out_valid_q;
  assign data_out          = out_data_q;
  assign startofpacket_out = out_sop_q;
  assign endofpacket_out   = out_eop_q;
  assign frame_error       = frame_error_q;
  assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_stream_border_skid.sv
// Testbench for stream_border_skid with a small 4x3 frame geometry.
// A frame-level reference model (beat index within frame, not x/y counters)
// predicts the output stream, error pulses and frame count.
module tb_stream_border_skid;

  localparam int W = 4;
  localparam int H = 3;
  localparam logic [29:0] BC = 30'h0ABCDEF;

  logic        clk;
  logic        reset;
  logic [29:0] data_in;
  logic        startofpacket_in;
  logic        endofpacket_in;
  logic        valid_in;
  logic        ready_out;
  logic [29:0] data_out;
  logic        startofpacket_out;
  logic        endofpacket_out;
  logic        valid_out;
  logic        ready_in;
  logic        frame_error;
  logic [15:0] frame_count;

  stream_border_skid #(.WIDTH(W), .HEIGHT(H), .BORDER_COLOR(BC)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .startofpacket_in(startofpacket_in), .endofpacket_in(endofpacket_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .startofpacket_out(startofpacket_out), .endofpacket_out(endofpacket_out),
    .valid_out(valid_out), .ready_in(ready_in),
    .frame_error(frame_error), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] d;
    logic        s;
    logic        e;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       out_log[$];
  logic [29:0] sent[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          err_pulses = 0;
  bit          m_in_frame = 0;
  int          m_pos = 0;
  logic        m_err = 1'b0;
  logic [15:0] m_cnt = 16'h0;
  bit          prev_stall = 0;
  beat_t       prev_beat;
  bit          was_rst = 1;
  int          rmode = 0;
  bit          tog = 0;

  function automatic bit is_border(input int idx);
    int x, y;
    x = idx % W;
    y = idx / W;
    return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
  endfunction

  // Cycle monitor: scoreboard of the output stream plus per-cycle status checks
  always @(negedge clk) begin
    beat_t got, exp_b, nb;
    bit    fwd, last;
    #1;
    if (!reset) begin
      exp_q.delete();
      m_in_frame = 0;
      m_pos = 0;
      m_err = 1'b0;
      m_cnt = 16'h0;
      prev_stall = 0;
      was_rst = 1;
    end else begin
      n_cmp++;
      if (frame_error !== m_err) begin
        n_fail++;
        $display("FAIL frame_error @%0t: got %b expected %b", $time, frame_error, m_err);
      end
      n_cmp++;
      if (frame_count !== m_cnt) begin
        n_fail++;
        $display("FAIL frame_count @%0t: got %h expected %h", $time, frame_count, m_cnt);
      end
      n_cmp++;
      if (valid_out !== ((exp_q.size() > 0) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL valid_out @%0t: got %b expected %0d beats pending", $time, valid_out, exp_q.size());
      end
      if (!was_rst) begin
        n_cmp++;
        if (ready_out !== ((exp_q.size() < 2) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL ready_out @%0t: got %b with %0d beats buffered", $time, ready_out, exp_q.size());
        end
      end
      got = {data_out, startofpacket_out, endofpacket_out};
      if (prev_stall) begin
        n_cmp++;
        if (valid_out !== 1'b1 || got !== prev_beat) begin
          n_fail++;
          $display("FAIL stall_stable @%0t: got v=%b %h expected v=1 %h", $time, valid_out, got, prev_beat);
        end
      end
      if (frame_error === 1'b1) err_pulses++;
      if (valid_out && ready_in) begin
        out_log.push_back(got);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL emit_extra @%0t: got %h expected no beat", $time, got);
        end else begin
          exp_b = exp_q.pop_front();
          if (got !== exp_b) begin
            n_fail++;
            $display("FAIL emit_beat @%0t: got d=%h s=%b e=%b expected d=%h s=%b e=%b",
                     $time, got.d, got.s, got.e, exp_b.d, exp_b.s, exp_b.e);
          end
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_beat = got;
      // Reference model of framing rules for the beat accepted at the coming edge
      m_err = 1'b0;
      if (valid_in && ready_out) begin
        fwd = 1;
        if (startofpacket_in) begin
          if (m_in_frame) m_err = 1'b1;
          m_in_frame = 1;
          m_pos = 0;
        end else if (!m_in_frame) begin
          fwd = 0;
          m_err = 1'b1;
        end
        if (fwd) begin
          last = (m_pos == W * H - 1);
          nb.d = is_border(m_pos) ? BC : data_in;
          nb.s = startofpacket_in;
          nb.e = endofpacket_in;
          if (endofpacket_in) begin
            if (last) m_cnt = m_cnt + 16'd1;
            else m_err = 1'b1;
            m_in_frame = 0;
          end else if (last) begin
            nb.e = 1'b1;
            m_err = 1'b1;
            m_in_frame = 0;
          end else begin
            m_pos++;
          end
          exp_q.push_back(nb);
        end
      end
      was_rst = 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_ready();
    case (rmode)
      0: ready_in = 1'b1;
      1: begin tog = ~tog; ready_in = tog; end
      2: ready_in = 1'($urandom_range(0, 1));
      default: ready_in = 1'b0;
    endcase
  endtask

  // Offer one beat and hold it until the block is ready to take it
  task automatic send(input logic [29:0] d, input bit s, input bit e);
    int  budget;
    bit  done;
    budget = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in = d;
      startofpacket_in = s;
      endofpacket_in = e;
      set_ready();
      sent.push_back(d);
      #1;
      if (ready_out) begin
        done = 1;
      end else begin
        void'(sent.pop_back());
        budget++;
        if (budget > 40) begin
          n_cmp++;
          n_fail++;
          $display("FAIL send_timeout: got ready_out=0 for 40 cycles expected 1");
          done = 1;
        end
      end
    end
  endtask

  task automatic send_frame(input int n, input int eop_at, input bit ramp, input int base);
    for (int i = 0; i < n; i++) begin
      send(ramp ? 30'(base + i) : 30'($urandom), i == 0, i == eop_at);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    do begin
      @(negedge clk);
      valid_in = 1'b0;
      startofpacket_in = 1'b0;
      endofpacket_in = 1'b0;
      set_ready();
      b++;
    end while (exp_q.size() > 0 && b < 300);
    @(negedge clk);
    valid_in = 1'b0;
    set_ready();
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats stuck expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    startofpacket_in = 1'b0;
    endofpacket_in = 1'b0;
    ready_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({ready_out, valid_out, startofpacket_out, endofpacket_out, frame_error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {ready_out, valid_out, startofpacket_out, endofpacket_out, frame_error});
    end
    n_cmp++;
    if (data_out !== 30'h0 || frame_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h count=%h expected 0/0", data_out, frame_count);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b expected 0", ready_out);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: got %b expected 1", ready_out);
    end
  endtask

  task automatic check_ramp(input string name);
    logic [29:0] want;
    n_cmp++;
    if (out_log.size() != W * H) begin
      n_fail++;
      $display("FAIL %s_len: got %0d expected %0d", name, out_log.size(), W * H);
    end else begin
      for (int i = 0; i < W * H; i++) begin
        want = (i == 5 || i == 6) ? 30'(i + 1) : BC;
        n_cmp++;
        if (out_log[i].d !== want || out_log[i].s !== (i == 0) || out_log[i].e !== (i == W * H - 1)) begin
          n_fail++;
          $display("FAIL %s_pix%0d: got %h s=%b e=%b expected %h", name, i,
                   out_log[i].d, out_log[i].s, out_log[i].e, want);
        end
      end
    end
  endtask

  task automatic test_basic_frame();
    int e0;
    e0 = err_pulses;
    out_log.delete();
    rmode = 0;
    send_frame(W * H, W * H - 1, 1, 1);
    drain();
    check_ramp("basic");
    n_cmp++;
    if (frame_count !== 16'd1 || err_pulses != e0) begin
      n_fail++;
      $display("FAIL basic_status: got count=%0d errs=%0d expected 1/0", frame_count, err_pulses - e0);
    end
  endtask

  task automatic test_backpressure();
    int e0;
    e0 = err_pulses;
    out_log.delete();
    rmode = 1;
    send_frame(W * H, W * H - 1, 1, 1);
    drain();
    check_ramp("toggle");
    out_log.delete();
    sent.delete();
    rmode = 2;
    send_frame(W * H, W * H - 1, 0, 0);
    drain();
    n_cmp++;
    if (out_log.size() != W * H) begin
      n_fail++;
      $display("FAIL random_len: got %0d expected %0d", out_log.size(), W * H);
    end else begin
      for (int i = 0; i < W * H; i++) begin
        n_cmp++;
        if (out_log[i].d !== (is_border(i) ? BC : sent[i])) begin
          n_fail++;
          $display("FAIL random_pix%0d: got %h expected %h", i, out_log[i].d,
                   is_border(i) ? BC : sent[i]);
        end
      end
    end
    n_cmp++;
    if (frame_count !== 16'd3 || err_pulses != e0) begin
      n_fail++;
      $display("FAIL backpressure_status: got count=%0d errs=%0d expected 3/0", frame_count, err_pulses - e0);
    end
  endtask

  task automatic test_no_sop();
    int e0;
    e0 = err_pulses;
    out_log.delete();
    rmode = 0;
    for (int i = 0; i < 3; i++) send(30'($urandom), 0, 0);
    rmode = 2;
    send_frame(W * H, W * H - 1, 0, 0);
    drain();
    n_cmp++;
    if (err_pulses - e0 != 3 || out_log.size() != W * H || frame_count !== 16'd4) begin
      n_fail++;
      $display("FAIL no_sop: got errs=%0d beats=%0d count=%0d expected 3/12/4",
               err_pulses - e0, out_log.size(), frame_count);
    end
  endtask

  task automatic test_early_eop();
    int e0;
    e0 = err_pulses;
    out_log.delete();
    rmode = 2;
    send_frame(7, 6, 0, 0);
    drain();
    n_cmp++;
    if (err_pulses - e0 != 1 || out_log.size() != 7 || frame_count !== 16'd4) begin
      n_fail++;
      $display("FAIL early_eop: got errs=%0d beats=%0d count=%0d expected 1/7/4",
               err_pulses - e0, out_log.size(), frame_count);
    end else begin
      n_cmp++;
      if (out_log[6].e !== 1'b1) begin
        n_fail++;
        $display("FAIL early_eop_flag: got %b expected 1", out_log[6].e);
      end
    end
    send_frame(W * H, W * H - 1, 0, 0);
    drain();
    n_cmp++;
    if (frame_count !== 16'd5 || err_pulses - e0 != 1) begin
      n_fail++;
      $display("FAIL after_early_eop: got count=%0d errs=%0d expected 5/1", frame_count, err_pulses - e0);
    end
  endtask

  task automatic test_missing_eop_and_resync();
    int e0;
    e0 = err_pulses;
    out_log.delete();
    sent.delete();
    rmode = 2;
    send_frame(W * H, -1, 0, 0);
    drain();
    n_cmp++;
    if (err_pulses - e0 != 1 || frame_count !== 16'd5 || out_log.size() != W * H) begin
      n_fail++;
      $display("FAIL missing_eop: got errs=%0d count=%0d beats=%0d expected 1/5/12",
               err_pulses - e0, frame_count, out_log.size());
    end else begin
      n_cmp++;
      if (out_log[W * H - 1].e !== 1'b1) begin
        n_fail++;
        $display("FAIL forced_eop: got %b expected 1", out_log[W * H - 1].e);
      end
    end
    send_frame(4, -1, 0, 0);
    send_frame(W * H, W * H - 1, 0, 0);
    drain();
    n_cmp++;
    if (err_pulses - e0 != 2 || frame_count !== 16'd6 || out_log.size() != 28) begin
      n_fail++;
      $display("FAIL sop_restart: got errs=%0d count=%0d beats=%0d expected 2/6/28",
               err_pulses - e0, frame_count, out_log.size());
    end else begin
      n_cmp++;
      if (out_log[16].s !== 1'b1 || out_log[16].d !== BC || out_log[17].d !== BC ||
          out_log[21].d !== sent[21]) begin
        n_fail++;
        $display("FAIL sop_restart_pos: got s=%b %h %h %h expected 1 %h %h %h",
                 out_log[16].s, out_log[16].d, out_log[17].d, out_log[21].d, BC, BC, sent[21]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int e0;
    rmode = 0;
    for (int i = 0; i < 5; i++) send(30'(i + 1), i == 0, 0);
    rmode = 3;
    send(30'd6, 0, 0);
    @(negedge clk);
    valid_in = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || frame_count !== 16'h0 || ready_out !== 1'b0 || frame_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b count=%h rdy=%b err=%b expected 0/0000/0/0",
               valid_out, frame_count, ready_out, frame_error);
    end
    @(negedge clk);
    reset = 1'b1;
    rmode = 0;
    out_log.delete();
    e0 = err_pulses;
    send(30'h1234, 0, 0);
    send_frame(W * H, W * H - 1, 0, 0);
    drain();
    n_cmp++;
    if (err_pulses - e0 != 1 || out_log.size() != W * H || frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL after_reset: got errs=%0d beats=%0d count=%0d expected 1/12/1",
               err_pulses - e0, out_log.size(), frame_count);
    end
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #3;
    release dut.frame_count_q;
    rmode = 2;
    send_frame(W * H, W * H - 1, 0, 0);
    drain();
    n_cmp++;
    if (frame_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL count_wrap: got %h expected 0000", frame_count);
    end
  endtask

  task automatic test_back_to_back();
    int e0, good, bad, kind, k;
    logic [15:0] c0;
    e0 = err_pulses;
    c0 = frame_count;
    good = 0;
    bad = 0;
    rmode = 2;
    for (int f = 0; f < 8; f++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        send_frame(W * H, W * H - 1, 0, 0);
        good++;
      end else if (kind == 1) begin
        send_frame(W * H, -1, 0, 0);
        bad++;
      end else begin
        k = $urandom_range(1, W * H - 1);
        send_frame(k, k - 1, 0, 0);
        bad++;
      end
    end
    drain();
    n_cmp++;
    if (frame_count !== 16'(c0 + good) || err_pulses - e0 != bad) begin
      n_fail++;
      $display("FAIL back_to_back: got count=%0d errs=%0d expected %0d/%0d",
               frame_count, err_pulses - e0, c0 + good, bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_no_sop();
    test_early_eop();
    test_missing_eop_and_resync();
    test_reset_midframe();
    test_count_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
